// File: rtl/jtframe_dump_ctrl.sv
// jtframe_dump_ctrl: frame-window dump controller.
//
// Counts frames on falling edges of vs. It drives a registered dump enable while the frame
// count lies inside any of WINDOWS programmable [start, start+len) windows. It also drives
// one-cycle start/stop strobes and a sticky done flag.
//
// Optional feature: define JTFRAME_DUMP_LOADROM_EN to arm counting on the falling edge of
// the downloading flag. Otherwise downloading is ignored and counting starts after reset.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   vs           vertical sync, active high; frames counted on its falling edge
//   downloading  ROM download in progress (used only with JTFRAME_DUMP_LOADROM_EN)
//   win_start    window i start frame in [i*CW +: CW]
//   win_len      window i length in [i*LW +: LW]; 0 disables window i
//   frame_cnt    saturating frame counter
//   win_active   per-window active flags (registered)
//   dump_on      OR of win_active (registered)
//   dump_start   one-cycle pulse, one cycle after dump_on rises
//   dump_stop    one-cycle pulse, one cycle after dump_on falls
//   done         all enabled windows have ended (sticky until reset)
module jtframe_dump_ctrl #(
  parameter int unsigned CW      = 32,
  parameter int unsigned LW      = 16,
  parameter int unsigned WINDOWS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vs,
  input  logic                 downloading,
  input  logic [WINDOWS*CW-1:0] win_start,
  input  logic [WINDOWS*LW-1:0] win_len,
  output logic [CW-1:0]        frame_cnt,
  output logic [WINDOWS-1:0]   win_active,
  output logic                 dump_on,
  output logic                 dump_start,
  output logic                 dump_stop,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WINDOWS-1:0]   win_q, win_d;
  logic                 dump_on_q, dump_on_d;
  logic                 dump_dly_q;
  logic                 dump_start_q, dump_start_d;
  logic                 dump_stop_q, dump_stop_d;
  logic                 done_q, done_d;
  logic                 vs_l_q;
  logic                 vs_fall;
  logic                 arm;
  logic                 hold;
  logic [WINDOWS-1:0]   in_range;
  logic [WINDOWS-1:0]   ended;
  logic                 all_ended;
  logic                 in_count;
  logic                 set_done;

  assign vs_fall = vs_l_q & ~vs;

`ifdef JTFRAME_DUMP_LOADROM_EN
  logic dl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) dl_q <= 1'b0;
    else        dl_q <= downloading;
  end

  assign arm  = dl_q & ~downloading;
  // Once done, a later download must not disturb the finished capture.
  assign hold = downloading & (state_q != StDone);
`else
  logic unused_downloading;
  assign unused_downloading = downloading;
  assign arm  = 1'b1;
  assign hold = 1'b0;
`endif

  // Window compares at CW+1 bits so a window ending past all-ones never wraps low.
  always_comb begin
    logic [CW:0] cnt_x, start_x, end_x;
    in_range = '0;
    ended    = '0;
    cnt_x    = {1'b0, cnt_q};
    start_x  = '0;
    end_x    = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      start_x     = {1'b0, win_start[i*CW +: CW]};
      end_x       = start_x + (CW+1)'(win_len[i*LW +: LW]);
      in_range[i] = (win_len[i*LW +: LW] != '0) && (cnt_x >= start_x) && (cnt_x < end_x);
      ended[i]    = (win_len[i*LW +: LW] == '0) || (cnt_x >= end_x);
    end
  end

  assign all_ended = &ended;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_count     = (state_q == StCount) && !hold;
    set_done     = in_count && all_ended;

    unique case (state_q)
      StIdle:  if (arm) state_d = StCount;
      StCount: if (set_done) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (hold) state_d = StIdle;

    if (hold) begin
      cnt_d = '0;
    end else if ((state_q != StIdle) && vs_fall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end

    win_d        = in_count ? in_range : '0;
    dump_on_d    = |win_d;
    // Pulses come from the registered dump_on and its delayed copy, so adjacent or
    // overlapping windows yield a single start/stop pair.
    dump_start_d = !hold && dump_on_q && !dump_dly_q;
    dump_stop_d  = !hold && !dump_on_q && dump_dly_q;
    done_d       = done_q | set_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      win_q        <= '0;
      dump_on_q    <= 1'b0;
      dump_dly_q   <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      done_q       <= 1'b0;
      vs_l_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      dump_on_q    <= dump_on_d;
      dump_dly_q   <= dump_on_q;
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
      done_q       <= done_d;
      vs_l_q       <= vs;
    end
  end

  assign frame_cnt  = cnt_q;
  assign win_active = win_q;
  assign dump_on    = dump_on_q;
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;
  assign done       = done_q;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: a 32-bit two-window instance plus a 4-bit
// single-window instance used for counter saturation.
module tb_jtframe_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst_nb, vs, downloading;
  logic [63:0] win_start;
  logic [31:0] win_len;
  logic [31:0] frame_cnt;
  logic [1:0]  win_active;
  logic        dump_on, dump_start, dump_stop, done;

  logic [3:0]  win_start_b, win_len_b;
  logic [3:0]  frame_cnt_b;
  logic        win_active_b, dump_on_b, dump_start_b, dump_stop_b, done_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_stop   = 0;
  int snap_start, snap_stop;
  logic [1:0] exp_wa [6];
  logic       exp_on [6];

  always #5 clk = ~clk;

  jtframe_dump_ctrl #(.CW(32), .LW(16), .WINDOWS(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .downloading (downloading),
    .win_start   (win_start),
    .win_len     (win_len),
    .frame_cnt   (frame_cnt),
    .win_active  (win_active),
    .dump_on     (dump_on),
    .dump_start  (dump_start),
    .dump_stop   (dump_stop),
    .done        (done)
  );

  jtframe_dump_ctrl #(.CW(4), .LW(4), .WINDOWS(1)) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_nb),
    .vs          (vs),
    .downloading (downloading),
    .win_start   (win_start_b),
    .win_len     (win_len_b),
    .frame_cnt   (frame_cnt_b),
    .win_active  (win_active_b),
    .dump_on     (dump_on_b),
    .dump_start  (dump_start_b),
    .dump_stop   (dump_stop_b),
    .done        (done_b)
  );

  always @(negedge clk) begin
    if (dump_start) n_start <= n_start + 1;
    if (dump_stop)  n_stop  <= n_stop + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vs high for two clocks, then low; frame_cnt moves on the first edge after the fall.
  task automatic do_frame(input int gap);
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic set_win(input int unsigned s0, input int unsigned l0,
                         input int unsigned s1, input int unsigned l1);
    win_start = {32'(s1), 32'(s0)};
    win_len   = {16'(l1), 16'(l0)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
  endtask

  // With the download-arming feature, a download pulse is needed before counting starts.
  task automatic arm();
`ifdef JTFRAME_DUMP_LOADROM_EN
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst_nb = 1'b0; vs = 1'b0; downloading = 1'b0;
    win_start_b = 4'd14; win_len_b = 4'd5;
    set_win(3, 2, 0, 0);
    repeat (3) tick();
    check("rst_cnt", frame_cnt, 0);
    check("rst_on", {31'd0, dump_on}, 0);
    check("rst_wa", {30'd0, win_active}, 0);
    check("rst_done", {31'd0, done}, 0);

    // Single window (3,2)
    rst_n = 1'b1;
    arm();
    tick();
    do_frame(6);
    do_frame(6);
    check("w1_cnt2", frame_cnt, 2);
    snap_start = n_start; snap_stop = n_stop;
    vs = 1'b1; tick(); tick(); vs = 1'b0;
    tick();
    check("w1_cnt3", frame_cnt, 3);
    check("w1_on_lat1", {31'd0, dump_on}, 0);
    tick();
    check("w1_on_lat2", {31'd0, dump_on}, 1);
    check("w1_wa", {30'd0, win_active}, 1);
    check("w1_start_early", {31'd0, dump_start}, 0);
    tick();
    check("w1_start", {31'd0, dump_start}, 1);
    tick();
    check("w1_start_end", {31'd0, dump_start}, 0);
    repeat (3) tick();
    do_frame(6);
    check("w1_cnt4_on", {31'd0, dump_on}, 1);
    vs = 1'b1; tick(); tick(); vs = 1'b0;
    tick();
    check("w1_cnt5", frame_cnt, 5);
    check("w1_on5", {31'd0, dump_on}, 1);
    check("w1_done_early", {31'd0, done}, 0);
    tick();
    check("w1_off", {31'd0, dump_on}, 0);
    check("w1_done", {31'd0, done}, 1);
    tick();
    check("w1_stop", {31'd0, dump_stop}, 1);
    tick();
    do_frame(6);
    check("w1_cnt6", frame_cnt, 6);
    check("w1_done_sticky", {31'd0, done}, 1);
    check("w1_nstart", n_start - snap_start, 1);
    check("w1_nstop", n_stop - snap_stop, 1);

    // Overlapping windows (2,3) and (4,2)
    set_win(2, 3, 4, 2);
    exp_wa = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
    exp_on = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    rst_n = 1'b1;
    arm();
    tick();
    snap_start = n_start; snap_stop = n_stop;
    for (int f = 0; f < 6; f++) begin
      do_frame(6);
      check($sformatf("ov_wa%0d", f + 1), {30'd0, win_active}, {30'd0, exp_wa[f]});
      check($sformatf("ov_on%0d", f + 1), {31'd0, dump_on}, {31'd0, exp_on[f]});
    end
    check("ov_done", {31'd0, done}, 1);
    check("ov_nstart", n_start - snap_start, 1);
    check("ov_nstop", n_stop - snap_stop, 1);

    // All windows disabled
    set_win(5, 0, 1, 0);
    do_reset();
    rst_n = 1'b1;
    arm();
    tick();
    check("len0_done1", {31'd0, done}, 0);
    tick();
    check("len0_done2", {31'd0, done}, 1);
    do_frame(6);
    check("len0_on", {31'd0, dump_on}, 0);

    // Reset during a dump
    set_win(3, 4, 0, 0);
    do_reset();
    rst_n = 1'b1;
    arm();
    tick();
    repeat (4) do_frame(6);
    check("mid_cnt4", frame_cnt, 4);
    check("mid_on", {31'd0, dump_on}, 1);
    snap_stop = n_stop;
    rst_n = 1'b0;
    tick();
    check("mid_rst_on", {31'd0, dump_on}, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_wa", {30'd0, win_active}, 0);
    tick();
    check("mid_rst_stop", {31'd0, dump_stop}, 0);
    check("mid_nstop", n_stop - snap_stop, 0);
    rst_n = 1'b1;
    arm();
    tick();
    do_frame(6);
    check("mid_restart", frame_cnt, 1);

`ifdef JTFRAME_DUMP_LOADROM_EN
    // Download holds the counter; its falling edge arms counting.
    set_win(1, 1, 0, 0);
    do_reset();
    rst_n = 1'b1;
    downloading = 1'b1;
    repeat (10) do_frame(4);
    check("dl_cnt_hold", frame_cnt, 0);
    check("dl_on_hold", {31'd0, dump_on}, 0);
    downloading = 1'b0;
    tick();
    check("dl_armed_cnt", frame_cnt, 0);
    do_frame(4);
    check("dl_cnt1", frame_cnt, 1);
    check("dl_on", {31'd0, dump_on}, 1);
`endif

    // Saturation on the 4-bit instance, window (14,5) ends past all-ones
    rst_nb = 1'b1;
    arm();
    tick();
    repeat (13) do_frame(4);
    check("sat_cnt13", {28'd0, frame_cnt_b}, 13);
    check("sat_off13", {31'd0, dump_on_b}, 0);
    do_frame(4);
    check("sat_on14", {31'd0, dump_on_b}, 1);
    repeat (3) do_frame(4);
    check("sat_cnt", {28'd0, frame_cnt_b}, 15);
    check("sat_on", {31'd0, dump_on_b}, 1);
    check("sat_done", {31'd0, done_b}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
